// File: rtl/pid_gain_manager.sv
// pid_gain_manager: owns the active Kp/Ki/Kd set fed to the PID core.
// Arbitrates host shadow writes against auto-tune runs and applies each new
// set atomically on a PID sample boundary.
module pid_gain_manager #(
  parameter int unsigned            GAIN_WIDTH     = 16,
  parameter int unsigned            TIMEOUT_CYCLES = 4_200_000,
  parameter logic [GAIN_WIDTH-1:0]  DEFAULT_KP     = 153,
  parameter logic [GAIN_WIDTH-1:0]  DEFAULT_KI     = 0,
  parameter logic [GAIN_WIDTH-1:0]  DEFAULT_KD     = 320
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  host_wr_valid,
  output logic                  host_wr_ready,
  input  logic [1:0]            host_wr_sel,
  input  logic [GAIN_WIDTH-1:0] host_wr_data,
  input  logic                  tune_req,
  output logic                  tune_start,
  input  logic                  tune_done,
  input  logic [GAIN_WIDTH-1:0] tune_kp,
  input  logic [GAIN_WIDTH-1:0] tune_ki,
  input  logic [GAIN_WIDTH-1:0] tune_kd,
  input  logic                  sample_tick,
  output logic [GAIN_WIDTH-1:0] pid_kp,
  output logic [GAIN_WIDTH-1:0] pid_ki,
  output logic [GAIN_WIDTH-1:0] pid_kd,
  output logic                  pid_hold,
  output logic                  gains_updated,
  output logic                  busy,
  output logic                  tune_error
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    TUNING = 2'd2,
    APPLY  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [GAIN_WIDTH-1:0] sh_kp_q, sh_kp_d, sh_ki_q, sh_ki_d, sh_kd_q, sh_kd_d;
  logic [GAIN_WIDTH-1:0] pd_kp_q, pd_kp_d, pd_ki_q, pd_ki_d, pd_kd_q, pd_kd_d;
  logic [GAIN_WIDTH-1:0] ac_kp_q, ac_kp_d, ac_ki_q, ac_ki_d, ac_kd_q, ac_kd_d;
  logic                  src_tuner_q, src_tuner_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  upd_q, upd_d;
  logic                  err_q, err_d;
  logic                  host_acc;

  // State, gain banks, timeout counter and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sh_kp_q     <= DEFAULT_KP;
      sh_ki_q     <= DEFAULT_KI;
      sh_kd_q     <= DEFAULT_KD;
      pd_kp_q     <= DEFAULT_KP;
      pd_ki_q     <= DEFAULT_KI;
      pd_kd_q     <= DEFAULT_KD;
      ac_kp_q     <= DEFAULT_KP;
      ac_ki_q     <= DEFAULT_KI;
      ac_kd_q     <= DEFAULT_KD;
      src_tuner_q <= 1'b0;
      cnt_q       <= '0;
      upd_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_kp_q     <= sh_kp_d;
      sh_ki_q     <= sh_ki_d;
      sh_kd_q     <= sh_kd_d;
      pd_kp_q     <= pd_kp_d;
      pd_ki_q     <= pd_ki_d;
      pd_kd_q     <= pd_kd_d;
      ac_kp_q     <= ac_kp_d;
      ac_ki_q     <= ac_ki_d;
      ac_kd_q     <= ac_kd_d;
      src_tuner_q <= src_tuner_d;
      cnt_q       <= cnt_d;
      upd_q       <= upd_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic: host/tuner arbitration, tuning sequencing, atomic apply
  always_comb begin
    state_d       = state_q;
    sh_kp_d       = sh_kp_q;
    sh_ki_d       = sh_ki_q;
    sh_kd_d       = sh_kd_q;
    pd_kp_d       = pd_kp_q;
    pd_ki_d       = pd_ki_q;
    pd_kd_d       = pd_kd_q;
    ac_kp_d       = ac_kp_q;
    ac_ki_d       = ac_ki_q;
    ac_kd_d       = ac_kd_q;
    src_tuner_d   = src_tuner_q;
    cnt_d         = cnt_q;
    upd_d         = 1'b0;
    err_d         = err_q;
    host_wr_ready = (state_q == IDLE) && !tune_req;
    host_acc      = host_wr_valid && host_wr_ready;

    case (state_q)
      IDLE: begin
        if (tune_req) begin
          state_d = START;
          err_d   = 1'b0;
        end else if (host_acc) begin
          case (host_wr_sel)
            2'd0: sh_kp_d = host_wr_data;
            2'd1: sh_ki_d = host_wr_data;
            2'd2: sh_kd_d = host_wr_data;
            default: begin
              pd_kp_d     = sh_kp_q;
              pd_ki_d     = sh_ki_q;
              pd_kd_d     = sh_kd_q;
              src_tuner_d = 1'b0;
              state_d     = APPLY;
            end
          endcase
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = TUNING;
      end
      TUNING: begin
        cnt_d = cnt_q + CW'(1);
        // A result arriving on the final timeout cycle still takes priority
        if (tune_done) begin
          pd_kp_d = tune_kp;
          pd_ki_d = tune_ki;
          pd_kd_d = tune_kd;
          if (tune_kp == '0) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            src_tuner_d = 1'b1;
            state_d     = APPLY;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      APPLY: begin
        if (sample_tick) begin
          ac_kp_d = pd_kp_q;
          ac_ki_d = pd_ki_q;
          ac_kd_d = pd_kd_q;
          upd_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tune_start    = (state_q == START);
  assign pid_hold      = (state_q == START) || (state_q == TUNING) ||
                         ((state_q == APPLY) && src_tuner_q);
  assign busy          = (state_q != IDLE);
  assign gains_updated = upd_q;
  assign tune_error    = err_q;
  assign pid_kp        = ac_kp_q;
  assign pid_ki        = ac_ki_q;
  assign pid_kd        = ac_kd_q;

endmodule

// File: tb/tb_pid_gain_manager.sv
// Directed bench for pid_gain_manager: a per-cycle vector table for host
// writes/arbitration plus hand sequences for tuning, timeout and reset.
module tb_pid_gain_manager;

  localparam int unsigned TMO = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_wr_valid;
  logic        host_wr_ready;
  logic [1:0]  host_wr_sel;
  logic [15:0] host_wr_data;
  logic        tune_req;
  logic        tune_start;
  logic        tune_done;
  logic [15:0] tune_kp, tune_ki, tune_kd;
  logic        sample_tick;
  logic [15:0] pid_kp, pid_ki, pid_kd;
  logic        pid_hold, gains_updated, busy, tune_error;

  int checks   = 0;
  int failures = 0;

  pid_gain_manager #(
    .GAIN_WIDTH     (16),
    .TIMEOUT_CYCLES (TMO),
    .DEFAULT_KP     (16'd153),
    .DEFAULT_KI     (16'd0),
    .DEFAULT_KD     (16'd320)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .host_wr_valid (host_wr_valid),
    .host_wr_ready (host_wr_ready),
    .host_wr_sel   (host_wr_sel),
    .host_wr_data  (host_wr_data),
    .tune_req      (tune_req),
    .tune_start    (tune_start),
    .tune_done     (tune_done),
    .tune_kp       (tune_kp),
    .tune_ki       (tune_ki),
    .tune_kd       (tune_kd),
    .sample_tick   (sample_tick),
    .pid_kp        (pid_kp),
    .pid_ki        (pid_ki),
    .pid_kd        (pid_kd),
    .pid_hold      (pid_hold),
    .gains_updated (gains_updated),
    .busy          (busy),
    .tune_error    (tune_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One row = one clock cycle: inputs held for the cycle, outputs seen in it.
  // flags = {ready, start, hold, updated, busy, error}
  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [15:0] d;
    logic        tr;
    logic        td;
    logic [15:0] tkp;
    logic        st;
    logic [47:0] gains;
    logic [5:0]  flags;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [1:0] sel, logic [15:0] d, logic tr,
                              logic td, logic [15:0] tkp, logic st,
                              logic [15:0] kp, logic [15:0] ki, logic [15:0] kd,
                              logic [5:0] flags);
    vec_t r;
    r.v = v; r.sel = sel; r.d = d; r.tr = tr; r.td = td; r.tkp = tkp; r.st = st;
    r.gains = {kp, ki, kd};
    r.flags = flags;
    return r;
  endfunction

  function automatic logic [5:0] flags_now();
    return {host_wr_ready, tune_start, pid_hold, gains_updated, busy, tune_error};
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, settle, then return for checks
  task automatic step(input logic v, input logic [1:0] sel, input logic [15:0] d,
                      input logic tr, input logic td, input logic [15:0] kp,
                      input logic [15:0] ki, input logic [15:0] kd, input logic st);
    @(negedge clk);
    host_wr_valid = v;
    host_wr_sel   = sel;
    host_wr_data  = d;
    tune_req      = tr;
    tune_done     = td;
    tune_kp       = kp;
    tune_ki       = ki;
    tune_kd       = kd;
    sample_tick   = st;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
  endtask

  task automatic req();
    step(1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
  endtask

  task automatic tick();
    step(1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1);
  endtask

  function automatic logic [47:0] g(logic [15:0] kp, logic [15:0] ki, logic [15:0] kd);
    return {kp, ki, kd};
  endfunction

  initial begin
    logic ok;
    int   starts;

    reset = 1'b1;
    host_wr_valid = 1'b0; host_wr_sel = '0; host_wr_data = '0;
    tune_req = 1'b0; tune_done = 1'b0; sample_tick = 1'b0;
    tune_kp = '0; tune_ki = '0; tune_kd = '0;

    // Host write/commit, coincident tick on commit edge, arbitration, bad result
    tbl.push_back(mk(0,0,0,    0,0,0,0, 153, 0,320, 6'b100000));
    tbl.push_back(mk(1,0,500,  0,0,0,0, 153, 0,320, 6'b100000));
    tbl.push_back(mk(1,1,12,   0,0,0,0, 153, 0,320, 6'b100000));
    tbl.push_back(mk(1,2,40,   0,0,0,0, 153, 0,320, 6'b100000));
    tbl.push_back(mk(1,3,0,    0,0,0,1, 153, 0,320, 6'b100000));
    tbl.push_back(mk(0,0,0,    0,0,0,0, 153, 0,320, 6'b000010));
    tbl.push_back(mk(0,0,0,    0,0,0,0, 153, 0,320, 6'b000010));
    tbl.push_back(mk(0,0,0,    0,0,0,1, 153, 0,320, 6'b000010));
    tbl.push_back(mk(0,0,0,    0,0,0,0, 500,12, 40, 6'b100100));
    tbl.push_back(mk(0,0,0,    0,0,0,0, 500,12, 40, 6'b100000));
    tbl.push_back(mk(1,0,9999, 1,0,0,0, 500,12, 40, 6'b000000));
    tbl.push_back(mk(1,0,9999, 0,0,0,0, 500,12, 40, 6'b011010));
    tbl.push_back(mk(1,0,9999, 0,0,0,0, 500,12, 40, 6'b001010));
    tbl.push_back(mk(0,0,0,    0,1,0,0, 500,12, 40, 6'b001010));
    tbl.push_back(mk(0,0,0,    0,0,0,0, 500,12, 40, 6'b100001));
    tbl.push_back(mk(1,3,0,    0,0,0,0, 500,12, 40, 6'b100001));
    tbl.push_back(mk(0,0,0,    0,0,0,1, 500,12, 40, 6'b000011));
    tbl.push_back(mk(0,0,0,    0,0,0,0, 500,12, 40, 6'b100101));
    tbl.push_back(mk(1,0,9999, 0,0,0,0, 500,12, 40, 6'b100001));
    tbl.push_back(mk(1,3,0,    0,0,0,0, 500,12, 40, 6'b100001));
    tbl.push_back(mk(0,0,0,    0,0,0,1, 500,12, 40, 6'b000011));
    tbl.push_back(mk(0,0,0,    0,0,0,0,9999,12, 40, 6'b100101));
    tbl.push_back(mk(0,0,0,    0,1,5,0,9999,12, 40, 6'b100001));
    tbl.push_back(mk(0,0,0,    0,0,0,0,9999,12, 40, 6'b100001));

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    idle();
    chk("reset gains", g(pid_kp, pid_ki, pid_kd), g(153, 0, 320));
    chk("reset flags", 48'(flags_now()), 48'(6'b100000));

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].tr, tbl[i].td, tbl[i].tkp,
           16'd0, 16'd0, tbl[i].st);
      chk($sformatf("row%0d gains", i), g(pid_kp, pid_ki, pid_kd), tbl[i].gains);
      chk($sformatf("row%0d flags", i), 48'(flags_now()), 48'(tbl[i].flags));
    end

    // Tune success: result after 30 TUNING cycles, tick after 5 APPLY cycles
    starts = 0;
    req();
    chk("A req flags", 48'(flags_now()), 48'(6'b000001));
    idle();
    starts += int'(tune_start);
    chk("A start flags", 48'(flags_now()), 48'(6'b011010));
    ok = 1'b1;
    for (int i = 0; i < 29; i++) begin
      idle();
      starts += int'(tune_start);
      ok &= pid_hold & busy & ~host_wr_ready;
    end
    chk("A tuning hold", 48'(ok), 48'(1'b1));
    step(1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 16'd700, 16'd33, 16'd88, 1'b0);
    chk("A done flags", 48'(flags_now()), 48'(6'b001010));
    chk("A start count", 48'(starts), 48'(1));
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle();
      ok &= pid_hold & busy & (g(pid_kp, pid_ki, pid_kd) == g(9999, 12, 40));
    end
    chk("A apply wait", 48'(ok), 48'(1'b1));
    tick();
    chk("A tick gains", g(pid_kp, pid_ki, pid_kd), g(9999, 12, 40));
    idle();
    chk("A new gains", g(pid_kp, pid_ki, pid_kd), g(700, 33, 88));
    chk("A update flags", 48'(flags_now()), 48'(6'b100100));
    idle();
    chk("A pulse end", 48'(flags_now()), 48'(6'b100000));

    // Timeout: 50 TUNING cycles with no result
    req();
    idle();
    chk("B start flags", 48'(flags_now()), 48'(6'b011010));
    ok = 1'b1;
    for (int i = 0; i < int'(TMO); i++) begin
      idle();
      ok &= pid_hold & busy & ~tune_error;
    end
    chk("B tuning window", 48'(ok), 48'(1'b1));
    idle();
    chk("B timeout flags", 48'(flags_now()), 48'(6'b100001));
    chk("B timeout gains", g(pid_kp, pid_ki, pid_kd), g(700, 33, 88));

    // Next request clears the error; result lands on the timeout cycle
    req();
    chk("C req flags", 48'(flags_now()), 48'(6'b000001));
    idle();
    chk("C error cleared", 48'(flags_now()), 48'(6'b011010));
    for (int i = 0; i < int'(TMO) - 1; i++) idle();
    step(1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 16'd1234, 16'd5, 16'd6, 1'b0);
    chk("C last cycle", 48'(flags_now()), 48'(6'b001010));
    idle();
    chk("C apply flags", 48'(flags_now()), 48'(6'b001010));
    tick();
    idle();
    chk("C gains", g(pid_kp, pid_ki, pid_kd), g(1234, 5, 6));
    chk("C update flags", 48'(flags_now()), 48'(6'b100100));

    // Reset mid-TUNING with a result presented on the reset edge
    req();
    idle();
    for (int i = 0; i < 10; i++) idle();
    @(negedge clk);
    reset = 1'b1;
    tune_done = 1'b1; tune_kp = 16'd42; tune_ki = 16'd42; tune_kd = 16'd42;
    @(negedge clk);
    reset = 1'b0;
    tune_done = 1'b0;
    #1;
    chk("D reset gains", g(pid_kp, pid_ki, pid_kd), g(153, 0, 320));
    chk("D reset flags", 48'(flags_now()), 48'(6'b100000));
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      ok &= ~gains_updated & ~busy & (g(pid_kp, pid_ki, pid_kd) == g(153, 0, 320));
    end
    chk("D quiet after reset", 48'(ok), 48'(1'b1));
    // Shadow bank was reset too: committing it applies the defaults
    step(1'b1, 2'd3, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0);
    tick();
    idle();
    chk("D shadow defaults", g(pid_kp, pid_ki, pid_kd), g(153, 0, 320));
    chk("D commit flags", 48'(flags_now()), 48'(6'b100100));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
